byte_frame_feeder: RTL and testbench
====================================

// Module: byte_frame_feeder
// PURPOSE
//  Upstream feeder for the 8-bit registered data-path cores. Accepts host bytes over valid/ready,
//  buffers them in a small FIFO, and emits one byte per clk on data_out (wired to the core's
//  data_in) as framed traffic: SOF byte, payload, 8-bit checksum byte. When no frame byte is
//  available it drives IDLE_BYTE. It also counts completed frames for the bench and the monitors.
// PARAMETERS
//  FIFO_DEPTH  8      entries in the payload buffer; power of 2, >= 2
//  SOF_BYTE    8'hA5  byte emitted at start of every frame
//  IDLE_BYTE   8'h00  byte driven when no frame byte is emitted
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   reset, asynchronous, active-high
//  in_valid     in   1   host byte valid
//  in_ready     out  1   feeder can accept a byte; equals !fifo_full
//  in_data      in   8   host payload byte
//  in_last      in   1   marks the final payload byte of a frame
//  data_out     out  8   framed stream to the core's data_in; registered
//  out_valid    out  1   1 = data_out carries a frame byte (SOF/payload/checksum)
//  out_sof      out  1   1 = data_out is SOF_BYTE
//  frame_count  out  16  completed frames; wraps 16'hFFFF -> 16'h0000
//  underrun     out  1   1-cycle pulse: payload byte needed but FIFO empty
// BEHAVIOUR
//  - Reset values: data_out=IDLE_BYTE, out_valid=0, out_sof=0, frame_count=0, underrun=0,
//    FSM=IDLE, FIFO empty, checksum=0. Reset mid-frame discards FIFO contents and the partial
//    frame; frame_count is not incremented.
//  - Push: in_valid && in_ready stores {in_last,in_data} (9 bits). in_ready depends on full only:
//    no push when full, even in a cycle with a pop. Pop never occurs when FIFO is empty.
//  - All outputs registered; each FSM state below lists the values registered at the edge.
//  - IDLE: FIFO non-empty -> data_out=SOF_BYTE, out_valid=1, out_sof=1, checksum<=0, go PAYLOAD.
//    FIFO empty -> data_out=IDLE_BYTE, out_valid=0, stay.
//  - PAYLOAD: FIFO non-empty -> pop, data_out=entry byte, out_valid=1, checksum<=checksum+byte
//    (mod 256). If entry.last, go CSUM; else stay.
//    FIFO empty -> data_out=IDLE_BYTE, out_valid=0, underrun=1 for this cycle, stay (frame resumes).
//  - CSUM: data_out=checksum (includes the last byte), out_valid=1, frame_count+1, go IDLE.
//  - out_sof is 1 only in the SOF cycle. underrun is 0 in every cycle other than a PAYLOAD stall.
//  - Latency: byte pushed at edge E0 into an empty, IDLE feeder -> SOF registered at E1,
//    that byte registered at E2. A frame of N payload bytes with no stalls takes N+2 output cycles.
//  - Back-to-back frames: CSUM -> IDLE -> SOF with no idle gap if the FIFO is non-empty.
//  - in_last on every byte (N=1): SOF, byte, checksum=byte.
// STRUCTURE
//  - Shared package/include: FSM state encodings (IDLE, PAYLOAD, CSUM), FIFO entry width
//    constant (9), default SOF/IDLE byte constants.
//  - One sub-module: byte_sync_fifo (DEPTH, WIDTH=9; push/pop/full/empty, pointers one bit
//    wider than log2(DEPTH)). The FSM, checksum and counters stay in byte_frame_feeder.
// TESTING
//  1 Reset: after rst, data_out=8'h00, out_valid=0, frame_count=0, in_ready=1; assert rst
//    mid-frame -> same values immediately, with no completed frame counted.
//  2 Frame {8'h01,8'h02,8'h03(last)} pushed -> data_out sequence A5,01,02,03,06, out_sof on A5,
//    then 00, frame_count=1.
//  3 Payload 8'hFF,8'h02(last) -> checksum 8'h01 (mod-256 wrap); a single byte 8'h7E(last)
//    -> A5,7E,7E.
//  4 Push 8'h10, wait 3 cycles, then push 8'h20(last) -> A5,10, then three 00 cycles with
//    underrun=1 and out_valid=0, then 20,30.
//  5 Fill FIFO with in_valid held and output stalled -> in_ready=0 after 8 entries, no data
//    lost or duplicated. Two back-to-back frames -> second A5 directly follows first checksum.
//  6 Preload frame_count to 16'hFFFF (force) and complete one frame -> frame_count=16'h0000.

Source files
------------

// File: rtl/byte_frame_feeder_pkg.sv
// Shared definitions for the byte frame feeder and its payload FIFO.
// Contents:
//   feeder_state_e     framing FSM states (IDLE, PAYLOAD, CSUM)
//   ENTRY_W            FIFO entry width: {last flag, payload byte}
//   DEFAULT_SOF_BYTE   start-of-frame marker byte
//   DEFAULT_IDLE_BYTE  filler byte driven between frames
package byte_frame_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CSUM    = 2'd2
  } feeder_state_e;

  localparam int         ENTRY_W           = 9;
  localparam logic [7:0] DEFAULT_SOF_BYTE  = 8'hA5;
  localparam logic [7:0] DEFAULT_IDLE_BYTE = 8'h00;

endpackage

// File: rtl/byte_sync_fifo.sv
// Single-clock FIFO holding payload entries for the frame feeder.
// The head entry is visible on rdata_o whenever empty_o is low, so the
// consumer can inspect it and pop in the same cycle.
// Ports:
//   clk, rst   clock (rising edge), asynchronous active-high reset
//   push_i     write wdata_i (ignored while full)
//   pop_i      discard the head entry (ignored while empty)
//   wdata_i    entry to store
//   rdata_o    current head entry
//   full_o     no free slot
//   empty_o    no stored entry
module byte_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the index bits coincide.
  logic [AW:0]      wrPtr_q;
  logic [AW:0]      rdPtr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             pushOk;
  logic             popOk;

  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                   (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign pushOk  = push_i && !full_o;
  assign popOk   = pop_i && !empty_o;
  assign rdata_o = mem_q[rdPtr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (pushOk) wrPtr_q <= wrPtr_q + PTR_ONE;
      if (popOk)  rdPtr_q <= rdPtr_q + PTR_ONE;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (pushOk) mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/byte_frame_feeder.sv
// Upstream feeder for the 8-bit registered data-path cores. Host bytes arrive
// over valid/ready, are buffered, and leave one per clock as framed traffic:
// SOF byte, payload bytes, then an 8-bit additive checksum byte.
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   in_valid     host byte valid
//   in_ready     buffer can accept a byte (not full)
//   in_data      host payload byte
//   in_last      final payload byte of the frame
//   data_out     registered framed stream (IDLE_BYTE when nothing to send)
//   out_valid    data_out carries a frame byte
//   out_sof      data_out is the SOF byte
//   frame_count  completed frames, wraps at 16 bits
//   underrun     one-cycle pulse when a payload byte was due but none buffered
module byte_frame_feeder
  import byte_frame_feeder_pkg::*;
#(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] SOF_BYTE   = DEFAULT_SOF_BYTE,
  parameter logic [7:0] IDLE_BYTE  = DEFAULT_IDLE_BYTE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic [7:0]  data_out,
  output logic        out_valid,
  output logic        out_sof,
  output logic [15:0] frame_count,
  output logic        underrun
);

  feeder_state_e      state_q, state_d;
  logic [7:0]         cksum_q, cksum_d;
  logic [7:0]         data_q, data_d;
  logic               valid_q, valid_d;
  logic               sof_q, sof_d;
  logic               underrun_q, underrun_d;
  logic [15:0]        count_q, count_d;

  logic               fifoFull;
  logic               fifoEmpty;
  logic               fifoPop;
  logic [ENTRY_W-1:0] fifoHead;
  logic [7:0]         headByte;
  logic               headLast;

  assign in_ready = !fifoFull;
  assign headByte = fifoHead[7:0];
  assign headLast = fifoHead[ENTRY_W-1];

  byte_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .pop_i   (fifoPop),
    .wdata_i ({in_last, in_data}),
    .rdata_o (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cksum_q    <= 8'h00;
      data_q     <= IDLE_BYTE;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      underrun_q <= 1'b0;
      count_q    <= 16'h0000;
    end else begin
      state_q    <= state_d;
      cksum_q    <= cksum_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      underrun_q <= underrun_d;
      count_q    <= count_d;
    end
  end

  // A payload stall leaves the FSM in PAYLOAD so the frame resumes with the
  // next buffered byte; the checksum accumulates across the stall.
  always_comb begin
    state_d    = state_q;
    cksum_d    = cksum_q;
    data_d     = IDLE_BYTE;
    valid_d    = 1'b0;
    sof_d      = 1'b0;
    underrun_d = 1'b0;
    count_d    = count_q;
    fifoPop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifoEmpty) begin
          data_d  = SOF_BYTE;
          valid_d = 1'b1;
          sof_d   = 1'b1;
          cksum_d = 8'h00;
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (!fifoEmpty) begin
          fifoPop = 1'b1;
          data_d  = headByte;
          valid_d = 1'b1;
          cksum_d = cksum_q + headByte;
          if (headLast) state_d = ST_CSUM;
        end else begin
          underrun_d = 1'b1;
        end
      end
      ST_CSUM: begin
        data_d  = cksum_q;
        valid_d = 1'b1;
        count_d = count_q + 16'd1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign data_out    = data_q;
  assign out_valid   = valid_q;
  assign out_sof     = sof_q;
  assign underrun    = underrun_q;
  assign frame_count = count_q;

endmodule

// File: tb/tb_byte_frame_feeder.sv
// Scoreboard bench for byte_frame_feeder: stimulus tasks queue the expected
// output bytes; a negedge monitor pops and compares whenever the DUT emits a
// frame byte or an underrun pulse, and tracks buffer occupancy for in_ready.
module tb_byte_frame_feeder;

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
    logic       sof;
    logic       under;
    logic       payload;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic [7:0]  data_out;
  logic        out_valid;
  logic        out_sof;
  logic [15:0] frame_count;
  logic        underrun;

  exp_t expQ[$];
  exp_t monE;
  int   vecCount = 0;
  int   missCount = 0;
  int   pushCount = 0;
  int   popCount = 0;
  int   curRun = 0;
  int   maxRun = 0;
  logic sawFull = 1'b0;

  byte_frame_feeder dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .data_out    (data_out),
    .out_valid   (out_valid),
    .out_sof     (out_sof),
    .frame_count (frame_count),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  // Monitor: compare every presented frame byte / underrun pulse against the
  // scoreboard, then check in_ready against the modelled occupancy.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid || underrun) begin
        vecCount++;
        if (expQ.size() == 0) begin
          missCount++;
          $display("[TB] FAIL stream: unexpected output data=%h valid=%b sof=%b underrun=%b, required no output",
                   data_out, out_valid, out_sof, underrun);
        end else begin
          monE = expQ.pop_front();
          if (data_out !== monE.data || out_valid !== monE.valid ||
              out_sof !== monE.sof || underrun !== monE.under) begin
            missCount++;
            $display("[TB] FAIL stream: got data=%h valid=%b sof=%b underrun=%b, required data=%h valid=%b sof=%b underrun=%b",
                     data_out, out_valid, out_sof, underrun,
                     monE.data, monE.valid, monE.sof, monE.under);
          end
          if (monE.payload) popCount++;
        end
      end
      vecCount++;
      if (in_ready !== ((pushCount - popCount) < 8)) begin
        missCount++;
        $display("[TB] FAIL in_ready: got %b, required %b (occupancy %0d)",
                 in_ready, ((pushCount - popCount) < 8), pushCount - popCount);
      end
      if (!in_ready) sawFull = 1'b1;
      if (out_valid) begin
        curRun++;
        if (curRun > maxRun) maxRun = curRun;
      end else begin
        curRun = 0;
      end
    end
  end

  task automatic pushExp(input logic [7:0] d, input logic v, input logic s,
                         input logic u, input logic p);
    exp_t e;
    e.data = d; e.valid = v; e.sof = s; e.under = u; e.payload = p;
    expQ.push_back(e);
  endtask

  // Present one byte and hold it until accepted (bounded wait).
  task automatic applyStimulus(input logic [7:0] d, input logic l);
    int waitCycles = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && waitCycles < 100) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) begin
      vecCount++;
      missCount++;
      $display("[TB] FAIL accept: in_ready stayed %b for byte %h, required 1", in_ready, d);
    end else begin
      @(posedge clk);
      pushCount++;
    end
    #1;
    in_valid = 1'b0;
  endtask

  // Queue expectations for one byte; csum is the hand-computed checksum of
  // the frame, used only on the last byte.
  task automatic sendByte(input logic [7:0] d, input logic first,
                          input logic last, input logic [7:0] csum);
    if (first) pushExp(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
    pushExp(d, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(d, last);
    if (last) pushExp(csum, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] required);
    vecCount++;
    if (actual !== required) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
    end
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (expQ.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    vecCount++;
    if (expQ.size() != 0) begin
      missCount++;
      $display("[TB] FAIL %s drain: %0d expected bytes never appeared, required 0", name, expQ.size());
      expQ.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " data_out"}, {8'h00, data_out}, 16'h0000);
    checkOutput({tag, " out_valid"}, {15'h0, out_valid}, 16'h0000);
    checkOutput({tag, " out_sof"}, {15'h0, out_sof}, 16'h0000);
    checkOutput({tag, " underrun"}, {15'h0, underrun}, 16'h0000);
    checkOutput({tag, " frame_count"}, frame_count, 16'h0000);
    checkOutput({tag, " in_ready"}, {15'h0, in_ready}, 16'h0001);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic frame: A5 01 02 03 06
    sendByte(8'h01, 1'b1, 1'b0, 8'h00);
    sendByte(8'h02, 1'b0, 1'b0, 8'h00);
    sendByte(8'h03, 1'b0, 1'b1, 8'h06);
    waitDrain("frame1");
    checkOutput("frame_count after frame1", frame_count, 16'h0001);

    // Reset mid-frame: A5 and 11 appear, the rest is discarded
    pushExp(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
    pushExp(8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h11, 1'b0);
    applyStimulus(8'h22, 1'b0);
    applyStimulus(8'h33, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkIdleOutputs("mid-frame reset");
    expQ.delete();
    pushCount = 0;
    popCount = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("frame_count after reset", frame_count, 16'h0000);

    // Checksum wrap and single-byte frame
    sendByte(8'hFF, 1'b1, 1'b0, 8'h00);
    sendByte(8'h02, 1'b0, 1'b1, 8'h01);
    sendByte(8'h7E, 1'b1, 1'b1, 8'h7E);
    waitDrain("wrap+single");
    checkOutput("frame_count after wrap+single", frame_count, 16'h0002);

    // Underrun: A5 10, three stall cycles, 20 30
    sendByte(8'h10, 1'b1, 1'b0, 8'h00);
    repeat (3) pushExp(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    sendByte(8'h20, 1'b0, 1'b1, 8'h30);
    waitDrain("underrun");
    checkOutput("frame_count after underrun", frame_count, 16'h0003);

    // Fill: 16 back-to-back single-byte frames with in_valid held
    maxRun = 0;
    sawFull = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sendByte(8'h40 + 8'(i), 1'b1, 1'b1, 8'h40 + 8'(i));
    end
    waitDrain("fill");
    checkOutput("in_ready deasserted when full", {15'h0, sawFull}, 16'h0001);
    checkOutput("back-to-back run length", 16'(maxRun), 16'd48);
    checkOutput("frame_count after fill", frame_count, 16'd19);

    // frame_count wrap
    @(negedge clk);
    force dut.count_q = 16'hFFFF;
    #1;
    release dut.count_q;
    checkOutput("frame_count preload", frame_count, 16'hFFFF);
    sendByte(8'h55, 1'b1, 1'b1, 8'h55);
    waitDrain("count wrap");
    checkOutput("frame_count wrap", frame_count, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
